// File: rtl/mem_if.sv
// Memory-side req/ack bus. The access unit is the master; the memory (or
// a bench model of it) is the slave.
interface mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-port sequencer for the multi-cycle control FSM. Accepts one fetch
// or data access per request, drives a variable-latency req/ack memory,
// stalls the control FSM until completion and owns IR and MDR.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for req_valid; checks alignment and latches the access
// REQ   | mem_req held; waiting for mem_ack or timeout expiry
// DONE  | one-cycle completion (done=1, stall released)
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_is_data,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              err_clr,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              err_misalign,
    output logic              err_timeout,
    mem_if.master             mem
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    // Timeout is a down-counter loaded on entry to REQ; reaching zero
    // without an ack means TIMEOUT REQ cycles have elapsed.
    localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              is_data;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [ADDR_W-1:0] addr_sel;
    logic              wr_sel;
    logic              misalign;
    logic              expire;
    logic              set_mis;
    logic              set_to;

    assign addr_sel = req_is_data ? data_addr : pc_addr;
    assign wr_sel   = req_write & req_is_data;
    assign misalign = |addr_sel[1:0];
    assign expire   = (TIMEOUT != 0) && (cnt == '0);
    assign set_mis  = (state == IDLE) && req_valid && misalign;
    assign set_to   = (state == REQ) && !mem.mem_ack && expire;

    assign stall          = req_valid & ~done;
    assign mem.mem_req    = mem_req_q;
    assign mem.mem_we     = mem_we_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_wdata  = mem_wdata_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode; ack wins over a same-cycle timeout expiry
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = misalign ? DONE : REQ;
            REQ:  if (mem.mem_ack || expire) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Access latch, timeout counter, IR/MDR capture and registered handshakes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            is_data     <= 1'b0;
            cnt         <= '0;
            done        <= 1'b0;
            ir          <= '0;
            mdr         <= '0;
        end else begin
            done      <= (state_nxt == DONE);
            mem_req_q <= (state_nxt == REQ);
            case (state)
                IDLE: if (req_valid && !misalign) begin
                    mem_addr_q  <= addr_sel;
                    mem_we_q    <= wr_sel;
                    mem_wdata_q <= wdata;
                    is_data     <= req_is_data;
                    cnt         <= CNT_LOAD;
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        mem_we_q <= 1'b0;
                        if (!mem_we_q) begin
                            if (is_data) mdr <= mem.mem_rdata;
                            else         ir  <= mem.mem_rdata;
                        end
                    end else if (expire) begin
                        mem_we_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as err_clr wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_misalign <= set_mis | (err_misalign & ~err_clr);
            err_timeout  <= set_to  | (err_timeout  & ~err_clr);
        end
    end

endmodule
